if_fetch_unit: RTL

Instruction-fetch stage that produces the `instruction`/`PC_Out` pair consumed by the IF/ID pipeline register. It owns the PC and issues one-outstanding requests to instruction memory. It holds the fetched word in a one-entry output buffer while the hazard unit stalls. Taken-branch redirects flush the buffer, and any in-flight memory response is discarded.

---
 rtl/if_pkg.sv | 23 ++
 rtl/if_fetch_buffer.sv | 34 +++
 rtl/if_fetch_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch slice.
// FETCH_MISALIGN_CHECK_EN adds the HALT state used after a misaligned redirect.
package if_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INCR = 4;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    FULL    = 3'd2,
`ifdef FETCH_MISALIGN_CHECK_EN
    DISCARD = 3'd3,
    HALT    = 3'd4
`else
    DISCARD = 3'd3
`endif
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_buffer.sv
// One-entry output buffer holding the fetched instruction and its PC for IF/ID.
// A flush only drops the valid flag; the held word stays visible but invalid.
module if_fetch_buffer
  import if_pkg::*;
#(
  parameter int unsigned XLEN    = if_pkg::XLEN,
  parameter int unsigned INSTR_W = if_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [XLEN-1:0]    load_pc,
  output logic [INSTR_W-1:0] instruction,
  output logic [XLEN-1:0]    pc_out,
  output logic               valid
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruction <= '0;
      pc_out      <= '0;
      valid       <= 1'b0;
    end else if (load) begin
      instruction <= load_instr;
      pc_out      <= load_pc;
      valid       <= 1'b1;
    end else if (flush) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request and
// feeds IF/ID through if_fetch_buffer. FETCH_MISALIGN_CHECK_EN enables HALT on misaligned redirects.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned      XLEN     = if_pkg::XLEN,
  parameter int unsigned      INSTR_W  = if_pkg::INSTR_W,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(if_pkg::RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    branch_target,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [XLEN-1:0]    PC_Out,
  output logic               fetch_valid
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic               fetch_misaligned
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] target;
  logic            buf_load, buf_flush;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic halt_pend_q, halt_pend_d;
  logic misaligned_q, misaligned_d;
  logic tgt_bad;

  assign tgt_bad = |branch_target[1:0];
  assign target  = branch_target;
`else
  assign target  = branch_target & ~XLEN'(2'b11);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt_pend_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      halt_pend_q  <= halt_pend_d;
      misaligned_q <= misaligned_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    buf_load   = 1'b0;
    buf_flush  = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    halt_pend_d  = halt_pend_q;
    misaligned_d = misaligned_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (branch_taken) begin
          pc_d       = target;
          req_addr_d = target;
          buf_flush  = 1'b1;
        end else begin
          req_addr_d = pc_q;
        end
      end
      REQ: begin
        if (branch_taken) begin
          pc_d      = target;
          buf_flush = 1'b1;
          if (imem_ready) begin
            req_addr_d = target;
            state_d    = REQ;
          end else begin
            state_d = DISCARD;
          end
        end else if (imem_ready) begin
          buf_load = 1'b1;
          pc_d     = req_addr_q + XLEN'(PC_INCR);
          state_d  = FULL;
        end
      end
      FULL: begin
        if (branch_taken) begin
          pc_d       = target;
          req_addr_d = target;
          buf_flush  = 1'b1;
          state_d    = REQ;
        end else if (!stall) begin
          req_addr_d = pc_q;
          buf_flush  = 1'b1;
          state_d    = REQ;
        end
      end
      DISCARD: begin
        if (branch_taken) begin
          pc_d = target;
          if (imem_ready) begin
            req_addr_d = target;
            state_d    = REQ;
          end
        end else if (imem_ready) begin
          req_addr_d = pc_q;
          state_d    = REQ;
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      HALT: ;
`endif
      default: state_d = IDLE;
    endcase
`ifdef FETCH_MISALIGN_CHECK_EN
    // A bad target is remembered until the bus is free; the latest redirect wins.
    if (branch_taken && state_q != HALT)
      halt_pend_d = tgt_bad;
    if (halt_pend_d && state_d == REQ) begin
      state_d      = HALT;
      misaligned_d = 1'b1;
      buf_flush    = 1'b1;
    end
`endif
  end

  assign imem_req  = (state_q == REQ) || (state_q == DISCARD);
  assign imem_addr = req_addr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_misaligned = misaligned_q;
`endif

  if_fetch_buffer #(
    .XLEN    (XLEN),
    .INSTR_W (INSTR_W)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .load        (buf_load),
    .flush       (buf_flush),
    .load_instr  (imem_rdata),
    .load_pc     (req_addr_q),
    .instruction (instruction),
    .pc_out      (PC_Out),
    .valid       (fetch_valid)
  );

endmodule
